// File: rtl/alu_op_encoder.sv
// rtl/alu_op_encoder.sv - RV32I opcode/funct3/funct7 to 4-bit ALU Operation encoder stage
//
// Purpose:
//   Decodes an RV32I instruction's opcode/funct3/funct7 into the ALU Operation
//   code and presents it through a registered, elastic stage. There is a
//   valid/ready handshake on both sides and a 2-entry buffer (output register
//   plus skid register). A saturating counter records accepted illegal ops.
//
// Ports:
//   clk           in   clock, all state on rising edge
//   reset         in   asynchronous, active-high reset
//   in_valid      in   upstream presents an instruction
//   in_ready      out  stage can accept this cycle (state != FULL)
//   in_opcode     in   instr[6:0]
//   in_funct3     in   instr[14:12]
//   in_funct7     in   instr[31:25]
//   in_tag        in   sideband tag, passed through unchanged
//   out_valid     out  out_operation/out_illegal/out_tag valid
//   out_ready     in   execute consumes this cycle
//   out_operation out  ALU Operation code
//   out_illegal   out  instruction not encodable (code 1111)
//   out_tag       out  tag of the presented op
//   illegal_count out  accepted illegal ops, saturating at all-ones

module alu_op_encoder #(
  parameter int OPCODE_LENGTH = 4,
  parameter int TAG_WIDTH     = 5,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [6:0]               in_opcode,
  input  logic [2:0]               in_funct3,
  input  logic [6:0]               in_funct7,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OPCODE_LENGTH-1:0] out_operation,
  output logic                     out_illegal,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [CNT_WIDTH-1:0]     illegal_count
);

  localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_ILL = OPCODE_LENGTH'(4'b1111);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [OPCODE_LENGTH-1:0] dec_operation;
  logic                     dec_illegal;

  logic accept;
  logic pop;
  logic load_out_from_in;
  logic load_out_from_skid;
  logic load_skid;

  logic [OPCODE_LENGTH-1:0] skid_operation;
  logic                     skid_illegal;
  logic [TAG_WIDTH-1:0]     skid_tag;

  // Instruction decode, purely from the input bus.
  always_comb begin
    dec_operation = OP_ILL;
    case (in_opcode)
      OPC_R: begin
        case (in_funct3)
          3'b000: begin
            if (in_funct7 == F7_ZERO)     dec_operation = OP_ADD;
            else if (in_funct7 == F7_ALT) dec_operation = OP_SUB;
          end
          3'b001:  if (in_funct7 == F7_ZERO) dec_operation = OP_SLL;
          3'b010:  if (in_funct7 == F7_ZERO) dec_operation = OP_SLT;
          3'b100:  if (in_funct7 == F7_ZERO) dec_operation = OP_XOR;
          3'b110:  if (in_funct7 == F7_ZERO) dec_operation = OP_OR;
          3'b111:  if (in_funct7 == F7_ZERO) dec_operation = OP_AND;
          default: dec_operation = OP_ILL;
        endcase
      end
      OPC_I: begin
        case (in_funct3)
          3'b000:  dec_operation = OP_ADD;
          // Only the shift-immediate form constrains funct7 (the shamt field sits below it).
          3'b001:  if (in_funct7 == F7_ZERO) dec_operation = OP_SLL;
          3'b010:  dec_operation = OP_SLT;
          3'b100:  dec_operation = OP_XOR;
          3'b110:  dec_operation = OP_OR;
          3'b111:  dec_operation = OP_AND;
          default: dec_operation = OP_ILL;
        endcase
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: dec_operation = OP_ADD;
      OPC_BRANCH: begin
        case (in_funct3)
          3'b000, 3'b001: dec_operation = OP_EQ;
          3'b100:         dec_operation = OP_SLT;
          default:        dec_operation = OP_ILL;
        endcase
      end
      default: dec_operation = OP_ILL;
    endcase
    dec_illegal = (dec_operation == OP_ILL);
  end

  // Both handshake outputs come only from the state register. This avoids
  // any combinational in->out path.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next         = state;
    load_out_from_in   = 1'b0;
    load_out_from_skid = 1'b0;
    load_skid          = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next       = ONE;
          load_out_from_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_out_from_in = 1'b1;
        end else if (accept) begin
          // The output entry is older, so the new op waits behind it in the skid.
          state_next = FULL;
          load_skid  = 1'b1;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next         = ONE;
          load_out_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_operation <= '0;
      out_illegal   <= 1'b0;
      out_tag       <= '0;
    end else if (load_out_from_in) begin
      out_operation <= dec_operation;
      out_illegal   <= dec_illegal;
      out_tag       <= in_tag;
    end else if (load_out_from_skid) begin
      out_operation <= skid_operation;
      out_illegal   <= skid_illegal;
      out_tag       <= skid_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_operation <= '0;
      skid_illegal   <= 1'b0;
      skid_tag       <= '0;
    end else if (load_skid) begin
      skid_operation <= dec_operation;
      skid_illegal   <= dec_illegal;
      skid_tag       <= in_tag;
    end
  end

  // The counter moves at accept time, so ops stalled in the buffer are already counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_count <= '0;
    end else if (accept && dec_illegal && (illegal_count != {CNT_WIDTH{1'b1}})) begin
      illegal_count <= illegal_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_op_encoder.sv
// tb/tb_alu_op_encoder.sv - directed self-checking bench for alu_op_encoder

module tb_alu_op_encoder;

  localparam int OW = 4;
  localparam int TW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [6:0]    in_opcode;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_operation;
  logic          out_illegal;
  logic [TW-1:0] out_tag;
  logic [CW-1:0] illegal_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  alu_op_encoder #(.OPCODE_LENGTH(OW), .TAG_WIDTH(TW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_operation(out_operation), .out_illegal(out_illegal), .out_tag(out_tag),
    .illegal_count(illegal_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [TW-1:0] t);
    in_opcode = opc;
    in_funct3 = f3;
    in_funct7 = f7;
    in_tag    = t;
  endtask

  // Present one op with out_ready=1, check it one cycle after accept.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [TW-1:0] t, input logic [3:0] exp_op);
    int budget;
    @(negedge clk);
    set_in(opc, f3, f7, t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    budget = 20;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (exp_op == 4'hF && exp_cnt < CNT_MAX) exp_cnt++;
    @(negedge clk);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_op"}, 32'(out_operation), 32'(exp_op));
    check({tag, "_ill"}, 32'(out_illegal), 32'(exp_op == 4'hF));
    check({tag, "_tag"}, 32'(out_tag), 32'(t));
    check({tag, "_cnt"}, 32'(illegal_count), 32'(exp_cnt));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    set_in(7'h00, 3'h0, 7'h00, '0);
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_op", 32'(out_operation), 32'd0);
    check("rst_ill", 32'(out_illegal), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    check("rst_cnt", 32'(illegal_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: R-type ADD then SUB
    run_op("t1_add", 7'b0110011, 3'b000, 7'h00, 5'd1, 4'b0010);
    run_op("t1_sub", 7'b0110011, 3'b000, 7'h20, 5'd2, 4'b0110);
    run_op("t1_r_and", 7'b0110011, 3'b111, 7'h00, 5'd3, 4'b0000);
    run_op("t1_r_or_bad_f7", 7'b0110011, 3'b110, 7'h20, 5'd4, 4'b1111);
    run_op("t1_i_or", 7'b0010011, 3'b110, 7'h55, 5'd5, 4'b0001);
    run_op("t1_i_sll", 7'b0010011, 3'b001, 7'h00, 5'd6, 4'b0100);
    run_op("t1_i_f3_101", 7'b0010011, 3'b101, 7'h00, 5'd7, 4'b1111);

    // 2: illegal I-shift and unknown opcode
    run_op("t2_sll_f7", 7'b0010011, 3'b001, 7'h20, 5'd8, 4'b1111);
    run_op("t2_opc7f", 7'b1111111, 3'b000, 7'h00, 5'd9, 4'b1111);
    check("t2_count", 32'(illegal_count), 32'd4);

    // 3: back-to-back push while stalled, then drain in order
    @(negedge clk);
    out_ready = 1'b0;
    set_in(7'b0110011, 3'b000, 7'h00, 5'd10);
    in_valid = 1'b1;
    @(posedge clk);
    #1 set_in(7'b0010011, 3'b100, 7'h00, 5'd11);
    @(posedge clk);
    #1 set_in(7'b1111111, 3'b000, 7'h00, 5'd12);
    @(negedge clk);
    check("t3_full_in_ready", 32'(in_ready), 32'd0);
    check("t3_full_valid", 32'(out_valid), 32'd1);
    check("t3_full_tag_a", 32'(out_tag), 32'd10);
    @(negedge clk);
    check("t3_hold_in_ready", 32'(in_ready), 32'd0);
    check("t3_hold_tag_a", 32'(out_tag), 32'd10);
    check("t3_hold_op_a", 32'(out_operation), 32'd2);
    check("t3_no_count", 32'(illegal_count), 32'(exp_cnt));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t3_tag_b", 32'(out_tag), 32'd11);
    check("t3_op_b", 32'(out_operation), 32'd3);
    check("t3_b_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("t3_drained", 32'(out_valid), 32'd0);

    // 4: branches and address-generating opcodes
    run_op("t4_beq", 7'b1100011, 3'b000, 7'h00, 5'd13, 4'b1000);
    run_op("t4_bne", 7'b1100011, 3'b001, 7'h00, 5'd14, 4'b1000);
    run_op("t4_blt", 7'b1100011, 3'b100, 7'h00, 5'd15, 4'b0111);
    run_op("t4_bge", 7'b1100011, 3'b101, 7'h00, 5'd16, 4'b1111);
    run_op("t4_load", 7'b0000011, 3'b010, 7'h7F, 5'd17, 4'b0010);
    run_op("t4_store", 7'b0100011, 3'b000, 7'h20, 5'd18, 4'b0010);
    run_op("t4_jalr", 7'b1100111, 3'b000, 7'h00, 5'd19, 4'b0010);

    // 5: drive counter to max-1, then saturate
    while (exp_cnt < CNT_MAX - 1) begin
      run_op("t5_fill", 7'b1111111, 3'b000, 7'h00, 5'd20, 4'b1111);
    end
    check("t5_max_minus1", 32'(illegal_count), 32'(CNT_MAX - 1));
    run_op("t5_to_max", 7'b0000000, 3'b000, 7'h00, 5'd21, 4'b1111);
    run_op("t5_sat", 7'b0110011, 3'b011, 7'h00, 5'd22, 4'b1111);
    check("t5_saturated", 32'(illegal_count), 32'(CNT_MAX));

    // 6: async reset while FULL
    @(negedge clk);
    out_ready = 1'b0;
    set_in(7'b0110011, 3'b000, 7'h20, 5'd23);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_tag = 5'd24;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("t6_full", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready), 32'd1);
    check("t6_rst_cnt", 32'(illegal_count), 32'd0);
    check("t6_rst_tag", 32'(out_tag), 32'd0);
    check("t6_rst_op", 32'(out_operation), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    exp_cnt = 0;
    run_op("t6_after", 7'b0110011, 3'b100, 7'h00, 5'd25, 4'b0011);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
